// File: rtl/hit_event_serializer.sv
// Serializes simultaneous per-target hit rises into one-hot des pulses.
// Each pulse is followed by an all-zero gap, so every hit gives exactly one score increment.
module hit_event_serializer #(
    parameter int N_TGT     = 10,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [N_TGT-1:0] hit,
    output logic [N_TGT-1:0] des,
    output logic             busy,
    output logic [N_TGT-1:0] pending,
    output logic             dropped
);

    localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [N_TGT-1:0] des_reg, des_next;
    logic [N_TGT-1:0] pending_reg, pending_next;
    logic [N_TGT-1:0] hit_d_reg;
    logic             dropped_reg, dropped_next;
    logic             busy_reg, busy_next;

    logic [N_TGT-1:0] rise;
    logic [N_TGT-1:0] clr;
    logic [N_TGT-1:0] sel_onehot;
    logic [N_TGT:0]   any_below;
    logic             launch;

    // Priority chain: bit 0 wins; the chain's last tap doubles as "anything pending".
    assign any_below[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < N_TGT; gi++) begin : g_prio
            assign sel_onehot[gi]    = pending_reg[gi] & ~any_below[gi];
            assign any_below[gi + 1] = any_below[gi] | pending_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        des_next   = des_reg;
        launch     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                des_next = '0;
                if (enable && any_below[N_TGT]) begin
                    launch = 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_reg == '0) begin
                    des_next   = '0;
                    cnt_next   = GAP_LOAD;
                    state_next = S_GAP;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            S_GAP: begin
                des_next = '0;
                if (cnt_reg == '0) begin
                    if (enable && any_below[N_TGT]) begin
                        launch = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                des_next   = '0;
                state_next = S_IDLE;
            end
        endcase

        if (launch) begin
            des_next   = sel_onehot;
            cnt_next   = PULSE_LOAD;
            state_next = S_PULSE;
        end

        // A rise on the bit being launched re-arms it: set beats clear.
        clr          = launch ? sel_onehot : '0;
        rise         = hit & ~hit_d_reg;
        pending_next = (pending_reg & ~clr) | rise;
        dropped_next = |(rise & pending_reg & ~clr);
        busy_next    = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            des_reg     <= '0;
            pending_reg <= '0;
            hit_d_reg   <= '0;
            dropped_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            des_reg     <= des_next;
            pending_reg <= pending_next;
            hit_d_reg   <= hit;
            dropped_reg <= dropped_next;
            busy_reg    <= busy_next;
        end
    end

    assign des     = des_reg;
    assign busy    = busy_reg;
    assign pending = pending_reg;
    assign dropped = dropped_reg;

endmodule

// File: tb/tb_hit_event_serializer.sv
// Bench for hit_event_serializer: directed scenarios plus random hit traffic,
// checked every cycle against a timeline model of launches and pending hits.
module tb_hit_event_serializer;

    localparam int N = 10;
    localparam int P = 2;
    localparam int G = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] hit = '0;
    logic [N-1:0] des;
    logic         busy;
    logic [N-1:0] pending;
    logic         dropped;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hit_event_serializer #(.N_TGT(N), .PULSE_LEN(P), .GAP_LEN(G)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .hit     (hit),
        .des     (des),
        .busy    (busy),
        .pending (pending),
        .dropped (dropped)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: each launch at edge s owns edges s..s+P+G-1; des is the event for the first P of them.
    logic [N-1:0] m_pending, m_hit_prev, m_evt;
    logic         m_dropped;
    int           m_cyc, m_start, m_free_at;
    int           m_launches = 0;

    task automatic model_reset();
        m_pending  = '0;
        m_hit_prev = '0;
        m_evt      = '0;
        m_dropped  = 1'b0;
        m_cyc      = 0;
        m_start    = -1000;
        m_free_at  = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] rise;
        logic [N-1:0] clr;
        m_cyc++;
        rise = hit & ~m_hit_prev;
        clr  = '0;
        if (m_cyc >= m_free_at && enable && m_pending != '0) begin
            for (int i = 0; i < N; i++) begin
                if (m_pending[i] && clr == '0) clr[i] = 1'b1;
            end
            m_evt     = clr;
            m_start   = m_cyc;
            m_free_at = m_cyc + P + G;
            m_launches++;
        end
        m_dropped  = |(rise & m_pending & ~clr);
        m_pending  = (m_pending & ~clr) | rise;
        m_hit_prev = hit;
    endtask

    function automatic logic [N-1:0] model_des();
        return (m_cyc - m_start < P) ? m_evt : '0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Compare process plus a downstream-decoder view (rises of |des, per-bit emissions, drops).
    int obs_rises = 0;
    int obs_drops = 0;
    int emit_cnt [N];
    logic prev_or = 1'b0;

    initial begin
        for (int i = 0; i < N; i++) emit_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rst_des", 32'(des), 32'(0));
                check("rst_busy", 32'(busy), 32'(0));
                check("rst_pending", 32'(pending), 32'(0));
                check("rst_dropped", 32'(dropped), 32'(0));
            end else begin
                check("model_des", 32'(des), 32'(model_des()));
                check("model_busy", 32'(busy), 32'(m_cyc < m_free_at));
                check("model_pending", 32'(pending), 32'(m_pending));
                check("model_dropped", 32'(dropped), 32'(m_dropped));
            end
            if ((|des) && !prev_or) begin
                obs_rises++;
                for (int i = 0; i < N; i++) if (des[i]) emit_cnt[i]++;
            end
            if (dropped === 1'b1) obs_drops++;
            prev_or = |des;
        end
    end

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (busy == 1'b0 && pending == '0 && des == '0) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b pending=%h, required idle within 200 cycles", busy, pending);
        end
    endtask

    logic [N-1:0] exp2 [13] = '{10'h000, 10'h001, 10'h001, 10'h000, 10'h000, 10'h008, 10'h008,
                                10'h000, 10'h000, 10'h080, 10'h080, 10'h000, 10'h000};
    logic [N-1:0] exp5 [8]  = '{10'h100, 10'h100, 10'h000, 10'h000, 10'h200, 10'h200, 10'h000, 10'h000};

    initial begin
        int base_a, base_b, base_d;
        logic [N-1:0] mask;

        // Reset
        repeat (3) @(negedge clk);
        check("reset_des", 32'(des), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        @(posedge clk); #2 reset_n = 1'b1;

        // 1: single held hit
        @(negedge clk); enable = 1'b1; hit = 10'h004;
        @(negedge clk); check("t1_pending", 32'(pending), 32'h004); check("t1_des0", 32'(des), 32'h0);
        @(negedge clk); check("t1_des1", 32'(des), 32'h004); check("t1_busy1", 32'(busy), 32'h1);
        @(negedge clk); check("t1_des2", 32'(des), 32'h004);
        @(negedge clk); check("t1_gap1", 32'(des), 32'h0); check("t1_busy3", 32'(busy), 32'h1);
        @(negedge clk); check("t1_gap2", 32'(des), 32'h0); check("t1_busy4", 32'(busy), 32'h1);
        @(negedge clk); check("t1_idle", 32'(busy), 32'h0); check("t1_pend0", 32'(pending), 32'h0);
        repeat (4) @(negedge clk);
        check("t1_once", 32'(emit_cnt[2]), 32'd1);
        hit = '0;
        @(negedge clk);

        // 2: simultaneous hits
        base_a = obs_rises;
        hit = 10'h089;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            hit = '0;
            check($sformatf("t2_des[%0d]", i), 32'(des), 32'(exp2[i]));
        end
        @(negedge clk); check("t2_idle", 32'(busy), 32'h0);
        check("t2_count", 32'(obs_rises - base_a), 32'd3);

        // 3: retrigger on an already-pending bit
        wait_idle();
        base_a = emit_cnt[5]; base_b = emit_cnt[1]; base_d = obs_drops;
        hit = 10'h022;
        @(negedge clk);
        @(negedge clk); check("t3_des", 32'(des), 32'h002); hit = 10'h002;
        @(negedge clk); hit = 10'h022;
        @(negedge clk); check("t3_drop", 32'(dropped), 32'h1);
        @(negedge clk); check("t3_drop_end", 32'(dropped), 32'h0); hit = '0;
        wait_idle();
        check("t3_emit5", 32'(emit_cnt[5] - base_a), 32'd1);
        check("t3_emit1", 32'(emit_cnt[1] - base_b), 32'd1);
        check("t3_drops", 32'(obs_drops - base_d), 32'd1);

        // 4: re-rise on the launch edge keeps the bit pending
        base_a = emit_cnt[2];
        enable = 1'b0; hit = 10'h004;
        @(negedge clk); hit = '0;
        @(negedge clk); hit = 10'h004; enable = 1'b1;
        @(negedge clk);
        check("t4_pending", 32'(pending), 32'h004);
        check("t4_des", 32'(des), 32'h004);
        check("t4_nodrop", 32'(dropped), 32'h0);
        @(negedge clk); check("t4_des2", 32'(des), 32'h004); hit = '0;
        @(negedge clk); check("t4_gap1", 32'(des), 32'h0);
        @(negedge clk); check("t4_gap2", 32'(des), 32'h0);
        @(negedge clk); check("t4_relaunch", 32'(des), 32'h004);
        wait_idle();
        check("t4_emit2", 32'(emit_cnt[2] - base_a), 32'd2);

        // 5: enable gating
        enable = 1'b0; hit = 10'h300;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_hold_pend", 32'(pending), 32'h300);
            check("t5_hold_des", 32'(des), 32'h0);
            check("t5_hold_busy", 32'(busy), 32'h0);
        end
        enable = 1'b1; hit = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("t5_des[%0d]", i), 32'(des), 32'(exp5[i]));
        end
        wait_idle();

        // 6: async reset mid-pulse
        base_a = emit_cnt[5];
        hit = 10'h030;
        @(negedge clk);
        @(negedge clk); check("t6_des", 32'(des), 32'h010); hit = '0;
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        check("t6_async_des", 32'(des), 32'h0);
        check("t6_async_pend", 32'(pending), 32'h0);
        check("t6_async_busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_no_stale", 32'(emit_cnt[5] - base_a), 32'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            mask = '0;
            for (int b = 0; b < N; b++) mask[b] = ($urandom_range(0, 11) == 0);
            hit    = hit ^ mask;
            enable = ($urandom_range(0, 9) != 0);
        end
        hit = '0; enable = 1'b1;
        wait_idle();
        check("total_events", 32'(obs_rises), 32'(m_launches));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hit_event_serializer.md
Name: hit_event_serializer

Overview:
- Sits directly upstream of the score display decoder and drives its 10-bit destroyed-target bus (des).
- The decoder increments once per rising edge of the OR of des, so two hits in the same cycle would count only once.
- This block edge-detects 10 per-target hit lines and queues pending hits. It replays each hit as a separate one-hot pulse followed by a mandatory all-zero gap, so every hit yields exactly one score increment.

Parameters:
N_TGT, 10, number of targets (width of hit/des/pending).
PULSE_LEN, 2, cycles des stays one-hot per event (>=1).
GAP_LEN, 2, cycles des is forced to zero after each pulse (>=1).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
enable  input  1  when low, no new event is launched; an event already in progress completes.
hit  input  N_TGT  per-target hit level from collision logic; a 0->1 transition is one event.
des  output  N_TGT  one-hot event pulse to the score decoder; all zero when idle or in gap.
busy  output  1  high in PULSE or GAP states.
pending  output  N_TGT  queued, not-yet-emitted events (registered).
dropped  output  1  one-cycle pulse: a rise arrived on a bit already pending (event merged/lost).

Behaviour:
- Reset (async, reset_n=0): state=IDLE; des=0, busy=0, pending=0, dropped=0; hit_d (previous hit) cleared; counter=0. Deassertion is sampled at the next clk edge. Reset mid-pulse drops des to 0 immediately and discards the queue.
- Edge detect: rise = hit & ~hit_d. hit_d <= hit every cycle.
- Pending update per bit, each edge: pending <= (pending & ~clr) | rise.
  - clr is the one-hot bit launched this edge.
  - If rise and clr hit the same bit in the same edge, set wins and the bit stays pending.
- dropped <= |(rise & pending & ~clr). A dropped pulse does not affect pending.
- Selection: the lowest-index set bit of pending (priority encoder, bit 0 highest priority).
- FSM, all outputs registered:
  - IDLE: if enable && pending!=0: des<=onehot(sel), clr=onehot(sel), cnt<=PULSE_LEN-1, go PULSE. Otherwise stay; des=0.
  - PULSE: des holds. If cnt==0: des<=0, cnt<=GAP_LEN-1, go GAP. Else cnt--.
  - GAP: des=0. If cnt==0:
    - if enable && pending!=0: launch the next event directly (same as the IDLE launch), go PULSE;
    - else go IDLE.
    Else cnt--.
- busy = (state!=IDLE), registered with state.
- Latency: hit rises before edge E0 -> pending bit set at E0 -> des asserted after E1, provided the FSM is IDLE and enable=1.
- Throughput: one event per PULSE_LEN+GAP_LEN cycles when back-to-back.
- des is never nonzero on two consecutive events without at least GAP_LEN zero cycles between them.
- des always has popcount <=1.
- Width rule: cnt is wide enough for max(PULSE_LEN,GAP_LEN)-1.
- A hit held high generates only one event; it must fall and rise again to generate another.
- enable dropped during PULSE or GAP: the current pulse and gap finish, then the FSM goes to IDLE and pending is retained.

Test Plan:
1. Reset then single hit: hit=10'h004 held from cycle 2 -> pending=10'h004 after the next edge; des=10'h004 for exactly 2 cycles starting 2 edges after the rise; then des=0; busy high 4 cycles; pending=0 afterwards; des goes high only once even though hit stays high.
2. Simultaneous hits: hit=10'h089 (bits 0,3,7) in one cycle -> des sequence 10'h001 (2 cycles), 0 (2), 10'h008 (2), 0 (2), 10'h080 (2), 0, then IDLE; the downstream count increases by 3.
3. Retrigger on pending bit: bit 5 rises; while bit 1 is emitting, bit 5 falls and rises again -> dropped pulses once for 1 cycle; bit 5 is emitted exactly once.
4. Set-wins collision: bit 2 re-rises on the exact edge it is launched -> pending[2] stays 1; bit 2 is emitted twice in total, separated by a gap of at least 2 cycles.
5. Enable gating: enable=0, hit=10'h300 -> pending=10'h300, des=0, busy=0. Then enable=1 -> 10'h100 then 10'h200 are emitted in order.
6. Async reset mid-pulse: assert reset_n=0 between clk edges while des=10'h010 -> des, pending and busy go to 0 without a clock edge; after release, no stale event is emitted.
